actuator_driver: RTL and testbench

ACTUATOR_DRIVER -- requirements
Module: actuator_driver

---
 rtl/actuator_pkg.sv | 22 ++
 rtl/limit_sync.sv | 21 ++
 rtl/actuator_driver.sv | 146 ++++++++++++++
 tb/tb_actuator_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/actuator_pkg.sv
// Shared state/direction encodings and default timing for the actuator driver.
package actuator_pkg;

   localparam int unsigned DEADTIME_CYC_DEF = 4;
   localparam int unsigned TIMEOUT_CYC_DEF  = 1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEADTIME,
      ST_DRIVE_OUT,
      ST_DRIVE_IN,
      ST_AT_POS,
      ST_FAULT,
      ST_ALARM
   } state_t;

   typedef enum logic {
      DIR_OUT,
      DIR_IN
   } dir_t;

endpackage

// File: rtl/limit_sync.sv
// Two-flop synchronizer for an asynchronous limit switch input.
module limit_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta     <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/actuator_driver.sv
// Bidirectional actuator driver: deadtime-guarded motor drive with limit,
// timeout, alarm and fault handling.
module actuator_driver
   import actuator_pkg::*;
#(
   parameter int unsigned DEADTIME_CYC = DEADTIME_CYC_DEF,
   parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic EN_RELEASE,
   input  logic EN_INSERT,
   input  logic EN_RESET,
   input  logic EN_ALARM,
   input  logic LIMIT_OUT,
   input  logic LIMIT_IN,
   output logic MOTOR_FWD,
   output logic MOTOR_REV,
   output logic BUSY,
   output logic DONE,
   output logic TIMEOUT_FAULT,
   output logic ALARM_OUT
);

   localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEADTIME_CYC - 1);
   localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYC);

   state_t            state, next_state;
   dir_t              dir, next_dir;
   logic [CNT_W-1:0]  cnt;
   logic              lim_out_s, lim_in_s;

   limit_sync u_sync_out (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (LIMIT_OUT),
      .sync_out (lim_out_s)
   );

   limit_sync u_sync_in (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (LIMIT_IN),
      .sync_out (lim_in_s)
   );

   always_comb begin
      next_state = state;
      next_dir   = dir;
      if (EN_ALARM) begin
         next_state = ST_ALARM;
      end else if (state == ST_ALARM) begin
         next_state = ST_IDLE;
      end else if (EN_RESET) begin
         next_state = ST_IDLE;
      end else if (EN_RELEASE && EN_INSERT) begin
         next_state = ST_FAULT;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (EN_RELEASE) begin
                  next_state = ST_DEADTIME;
                  next_dir   = DIR_OUT;
               end else if (EN_INSERT) begin
                  next_state = ST_DEADTIME;
                  next_dir   = DIR_IN;
               end
            end
            ST_DEADTIME: begin
               if (cnt >= DT_LAST)
                  next_state = (dir == DIR_OUT) ? ST_DRIVE_OUT : ST_DRIVE_IN;
            end
            ST_DRIVE_OUT: begin
               if (lim_out_s) begin
                  next_state = ST_AT_POS;
               end else if (cnt >= TO_MAX) begin
                  next_state = ST_FAULT;
               end else if (EN_INSERT) begin
                  next_state = ST_DEADTIME;
                  next_dir   = DIR_IN;
               end else if (!EN_RELEASE) begin
                  next_state = ST_IDLE;
               end
            end
            ST_DRIVE_IN: begin
               if (lim_in_s) begin
                  next_state = ST_AT_POS;
               end else if (cnt >= TO_MAX) begin
                  next_state = ST_FAULT;
               end else if (EN_RELEASE) begin
                  next_state = ST_DEADTIME;
                  next_dir   = DIR_OUT;
               end else if (!EN_INSERT) begin
                  next_state = ST_IDLE;
               end
            end
            ST_AT_POS: begin
               if (!EN_RELEASE && !EN_INSERT) begin
                  next_state = ST_IDLE;
               end else if (dir == DIR_OUT && EN_INSERT) begin
                  next_state = ST_DEADTIME;
                  next_dir   = DIR_IN;
               end else if (dir == DIR_IN && EN_RELEASE) begin
                  next_state = ST_DEADTIME;
                  next_dir   = DIR_OUT;
               end
            end
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_IDLE;
         endcase
      end
   end

   // Motor bits need both the current and next state in DRIVE: they rise one
   // edge after entry (deadtime+1 latency) yet fall on the very edge of exit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         dir           <= DIR_OUT;
         cnt           <= '0;
         MOTOR_FWD     <= 1'b0;
         MOTOR_REV     <= 1'b0;
         BUSY          <= 1'b0;
         DONE          <= 1'b0;
         TIMEOUT_FAULT <= 1'b0;
         ALARM_OUT     <= 1'b0;
      end else begin
         state <= next_state;
         dir   <= next_dir;
         if (next_state != state)
            cnt <= '0;
         else if (cnt != TO_MAX)
            cnt <= cnt + CNT_W'(1);
         MOTOR_FWD     <= (state == ST_DRIVE_OUT) && (next_state == ST_DRIVE_OUT);
         MOTOR_REV     <= (state == ST_DRIVE_IN) && (next_state == ST_DRIVE_IN);
         BUSY          <= (next_state == ST_DEADTIME) || (next_state == ST_DRIVE_OUT) ||
                          (next_state == ST_DRIVE_IN);
         DONE          <= ((state == ST_DRIVE_OUT) || (state == ST_DRIVE_IN)) &&
                          (next_state == ST_AT_POS);
         TIMEOUT_FAULT <= (next_state == ST_FAULT);
         ALARM_OUT     <= (next_state == ST_ALARM);
      end
   end

endmodule

// File: tb/tb_actuator_driver.sv
// Self-checking bench for actuator_driver (DEADTIME_CYC=4, TIMEOUT_CYC=20).
module tb_actuator_driver;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic EN_RELEASE = 1'b0, EN_INSERT = 1'b0, EN_RESET = 1'b0, EN_ALARM = 1'b0;
   logic LIMIT_OUT = 1'b0, LIMIT_IN = 1'b0;
   logic MOTOR_FWD, MOTOR_REV, BUSY, DONE, TIMEOUT_FAULT, ALARM_OUT;
   logic [5:0] outs;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;

   typedef struct {
      int unsigned cyc;
      string       nm;
      logic [5:0]  val;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      logic        rel, ins, rst, alm, lout, lin;
      int unsigned hold;
      logic [5:0]  exp;
   } vec_t;
   vec_t tbl[19];

   actuator_driver #(.DEADTIME_CYC(4), .TIMEOUT_CYC(20)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .EN_RELEASE    (EN_RELEASE),
      .EN_INSERT     (EN_INSERT),
      .EN_RESET      (EN_RESET),
      .EN_ALARM      (EN_ALARM),
      .LIMIT_OUT     (LIMIT_OUT),
      .LIMIT_IN      (LIMIT_IN),
      .MOTOR_FWD     (MOTOR_FWD),
      .MOTOR_REV     (MOTOR_REV),
      .BUSY          (BUSY),
      .DONE          (DONE),
      .TIMEOUT_FAULT (TIMEOUT_FAULT),
      .ALARM_OUT     (ALARM_OUT)
   );

   // {MOTOR_FWD, MOTOR_REV, BUSY, DONE, TIMEOUT_FAULT, ALARM_OUT}
   assign outs = {MOTOR_FWD, MOTOR_REV, BUSY, DONE, TIMEOUT_FAULT, ALARM_OUT};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge clk)
      assert (!(MOTOR_FWD && MOTOR_REV)) else $error("FAIL motor_overlap: both motor outputs high");

   function automatic void check(string nm, logic [5:0] act, logic [5:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Scoreboard drain: compare entries due after the edge just taken.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].nm, outs, sb[i].val);
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            check({sb[i].nm, "_missed"}, 6'bxxxxxx, sb[i].val);
            sb.delete(i);
         end
      end
      total++;
      if (MOTOR_FWD && MOTOR_REV) begin
         bad++;
         $display("FAIL both_motor: got FWD=%b REV=%b want not both high", MOTOR_FWD, MOTOR_REV);
      end
   end

   task automatic tick(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // n counts edges after the next edge (n=0 -> state right after it samples the inputs).
   task automatic expect_after(input int unsigned n, input string nm, input logic [5:0] v);
      sb.push_back('{cyc + 1 + n, nm, v});
   endtask

   task automatic drive(input logic rel, ins, rst, alm, lout, lin);
      EN_RELEASE = rel; EN_INSERT = ins; EN_RESET = rst;
      EN_ALARM = alm; LIMIT_OUT = lout; LIMIT_IN = lin;
   endtask

   initial begin
      //          rel   ins   rst   alm   lout  lin  hold  exp
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 6'b001000};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 6'b001000};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 6'b001000};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 6'b101000};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 6'b101000};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 6'b101000};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 6'b000100};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 6'b000000};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 6'b001000};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 6'b001000};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 6'b000000};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 6'b000010};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 6'b000010};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6, 6'b000010};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 6'b000000};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 6'b000001};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 6'b000001};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 6'b000000};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 6'b000000};

      #2 rst_n = 1'b0;
      #1 check("reset_outputs", outs, 6'b000000);
      tick(2);
      rst_n = 1'b1;
      expect_after(0, "idle_after_reset", 6'b000000);
      tick(2);

      foreach (tbl[i]) begin
         drive(tbl[i].rel, tbl[i].ins, tbl[i].rst, tbl[i].alm, tbl[i].lout, tbl[i].lin);
         expect_after(tbl[i].hold - 1, $sformatf("tbl%0d", i), tbl[i].exp);
         tick(tbl[i].hold);
      end

      // Inward drive with no limit: 20 motor cycles, then timeout fault.
      drive(0, 1, 0, 0, 0, 0);
      expect_after(4,  "to_drive_entry", 6'b001000);
      expect_after(5,  "to_rev_on",      6'b011000);
      expect_after(24, "to_rev_last",    6'b011000);
      expect_after(25, "to_fault",       6'b000010);
      tick(26);
      drive(0, 0, 1, 0, 0, 0);
      expect_after(0, "to_reset_clear", 6'b000000);
      tick(1);
      drive(0, 0, 0, 0, 0, 0);
      tick(1);

      // Reversal mid-drive goes through a full deadtime.
      drive(1, 0, 0, 0, 0, 0);
      expect_after(5, "rv_fwd_on", 6'b101000);
      tick(8);
      drive(0, 1, 0, 0, 0, 0);
      expect_after(0, "rv_fwd_off",  6'b001000);
      expect_after(4, "rv_dt_end",   6'b001000);
      expect_after(5, "rv_rev_on",   6'b011000);
      tick(7);

      // Alarm mid-drive, then release.
      drive(0, 1, 0, 1, 0, 0);
      expect_after(0, "alarm_enter", 6'b000001);
      tick(1);
      drive(0, 0, 0, 0, 0, 0);
      expect_after(0, "alarm_exit", 6'b000000);
      tick(2);

      // Limit already high when the drive state is entered.
      drive(0, 0, 0, 0, 0, 1);
      tick(3);
      drive(0, 1, 0, 0, 0, 1);
      expect_after(4, "pre_lim_entry", 6'b001000);
      expect_after(5, "pre_lim_done",  6'b000100);
      expect_after(6, "pre_lim_hold",  6'b000000);
      tick(7);
      drive(1, 0, 0, 0, 0, 0);
      expect_after(0, "atpos_reverse", 6'b001000);
      tick(1);
      drive(0, 0, 0, 0, 0, 0);
      tick(8);

      // Asynchronous reset mid-drive, then a full deadtime after release.
      drive(1, 0, 0, 0, 0, 0);
      expect_after(5, "rst_pre_fwd", 6'b101000);
      tick(7);
      #3 rst_n = 1'b0;
      #1 check("async_reset", outs, 6'b000000);
      tick(2);
      rst_n = 1'b1;
      expect_after(0, "post_rst_dt",     6'b001000);
      expect_after(4, "post_rst_dt_end", 6'b001000);
      expect_after(5, "post_rst_fwd",    6'b101000);
      tick(6);
      drive(0, 0, 0, 0, 0, 0);
      tick(3);

      for (int n = 0; n < 10 && sb.size() != 0; n++) tick(1);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
